// File: rtl/wishbone_data_bus_if.sv
// Bridges the core's single-cycle data-RAM port to a Wishbone B4 classic master.
// Optional bus timeout: define WB_TIMEOUT_EN.
module wishbone_data_bus_if #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  input  logic [DATA_W-1:0]   wishbone_data_i,
  input  logic                wishbone_ack_i,
  output logic [ADDR_W-1:0]   wishbone_addr_o,
  output logic [DATA_W-1:0]   wishbone_data_o,
  output logic                wishbone_we_o,
  output logic [DATA_W/8-1:0] wishbone_sel_o,
  output logic                wishbone_stb_o,
  output logic                wishbone_cyc_o,
  output logic                bus_err_o
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                stb_q, stb_d;
  logic                cyc_q, cyc_d;
  logic                timeout;

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Flush already aborts the access, so it masks the timeout.
  assign timeout = (state_q == BUSY) && !wishbone_ack_i &&
                   !flush_i && (cnt_q == TO_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rd_buf_d = rd_buf_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
`ifdef WB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = BUSY;
`ifdef WB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (flush_i || wishbone_ack_i || timeout) begin
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          state_d = IDLE;
          rd_buf_d = '0;
          if (!flush_i && wishbone_ack_i) begin
            rd_buf_d = wishbone_data_i;
            if (stall_i != 6'd0) state_d = WAIT_FOR_STALL;
          end
        end
`ifdef WB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      WAIT_FOR_STALL: begin
        if (stall_i == 6'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    bus_err_o  = 1'b0;
    unique case (state_q)
      IDLE: stallreq_o = cpu_ce_i && !flush_i;
      BUSY: begin
        if (wishbone_ack_i) begin
          cpu_data_o = we_q ? '0 : wishbone_data_i;
        end else if (timeout) begin
          bus_err_o  = 1'b1;
          cpu_data_o = DATA_W'(32'hDEADBEEF);
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WAIT_FOR_STALL: cpu_data_o = rd_buf_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_buf_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      rd_buf_q <= rd_buf_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
`ifdef WB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdata_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = stb_q;
  assign wishbone_cyc_o  = cyc_q;

endmodule
